instruction_fetch: RTL
======================

# instruction_fetch

- Front end of the pipelined RV32I CPU.
- Owns the program counter and drives the synchronous instruction memory (1-cycle read latency).
- Implements the IF/ID pipeline register: delivers `inst`, `pc` and `pc4` to the decode stage.
- Handles hazard-unit stalls and branch/jump redirects, including holding and killing in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `IMEM_AW`, default 14: instruction-memory word-address width.
- `NOP_INST`, default 32'h0000_0013: instruction (`addi x0,x0,0`) presented to decode while the IF/ID slot is invalid.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `stall`  in  1: hazard unit holds IF and IF/ID (load-use).
- `redirect`  in  1: EX-resolved taken branch / JAL / JALR.
- `redirect_pc`  in  32: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_addr`  out  IMEM_AW: word address to instruction memory, equal to `pc_f[IMEM_AW+1:2]`.
- `imem_rdata`  in  32: instruction word for the address presented in the previous cycle.
- `if_id_valid`  out  1: IF/ID slot holds a real instruction.
- `if_id_pc`  out  32: PC of the instruction in IF/ID.
- `if_id_pc4`  out  32: `if_id_pc + 4`, modulo 2^32.
- `if_id_inst`  out  32: instruction to decode.

## Operation
Registers:
- `pc_f` (32): fetch PC.
- `if_id_pc` (32), `if_id_valid` (1).
- `hold_inst` (32), `held` (1).

Per-edge priority: `rst` > `redirect` > `stall` > advance.
- `rst`:
  - `pc_f` <= RESET_PC.
  - `if_id_valid` <= 0, `if_id_pc` <= 0.
  - `held` <= 0, `hold_inst` <= 0.
- `redirect`:
  - `pc_f` <= {redirect_pc[31:2], 2'b00}.
  - `if_id_valid` <= 0. This kills the word arriving next cycle.
  - `held` <= 0.
  - `if_id_pc` is left unchanged.
  - Applies even when `stall` is also asserted.
- `stall` (no redirect):
  - `pc_f`, `if_id_pc` and `if_id_valid` hold.
  - If `held`=0: `hold_inst` <= `imem_rdata` and `held` <= 1.
  - If `held`=1: `hold_inst` is unchanged. Multi-cycle stalls keep the first captured word.
- Advance:
  - `if_id_pc` <= `pc_f`.
  - `if_id_valid` <= 1.
  - `pc_f` <= `pc_f` + 4 (wraps at 2^32).
  - `held` <= 0.

Combinational outputs:
- `if_id_inst`:
  - `NOP_INST` when `if_id_valid`=0.
  - Otherwise `hold_inst` when `held`=1.
  - Otherwise `imem_rdata`.
- `if_id_pc4` = `if_id_pc` + 4.
- `imem_addr` is a truncation of `pc_f`; upper bits beyond IMEM_AW+1 are discarded, so the address wraps within memory.

Rationale for `hold_inst`: during a stall, the memory re-reads `pc_f`, which is the *next* instruction. The word belonging to IF/ID must therefore be preserved in `hold_inst`.

## Timing
- Reset values:
  - `pc_f` = RESET_PC, so `imem_addr` = RESET_PC[IMEM_AW+1:2].
  - `if_id_valid` = 0, `if_id_pc` = 0, `if_id_pc4` = 4, `if_id_inst` = NOP_INST.
- Fetch latency: address presented in cycle N; the instruction appears valid in IF/ID in cycle N+1, if not stalled or redirected at edge N.
- First valid instruction: one cycle after `rst` deasserts.
- Redirect penalty:
  - `redirect` sampled at edge N.
  - Target address is presented in cycle N+1.
  - Target instruction is valid in IF/ID in cycle N+2.
  - Exactly one bubble (NOP) occurs in cycle N+1.
- Stall:
  - While `stall`=1, IF/ID outputs are stable cycle-to-cycle.
  - On the first advance after the stall, the next sequential instruction enters IF/ID with no bubble.
- Back-to-back redirects: each new redirect overrides the previous target. Only the last target is fetched.
- Redirect during a bubble (`if_id_valid`=0): same behaviour as a normal redirect.
- `rst` mid-stall or mid-redirect: reset wins and all state returns to reset values.

## Test plan
- Reset then free-run, with imem word k = 32'h1000_0000+k: cycles 1..4 after reset show `if_id_pc` = 0,4,8,12; `if_id_inst` = 1000_0000..1000_0003; `if_id_pc4` = 4,8,12,16; cycle 0 shows NOP with valid=0.
- Stall 3 cycles while `if_id_pc`=8: `if_id_inst` stays 1000_0002 and `imem_addr` stays 3 for all 3 cycles. After release, pc 12 follows with inst 1000_0003 and no bubble.
- Redirect to 32'h0000_0043 while IF/ID holds pc 4: next cycle valid=0 with NOP; following cycle `if_id_pc`=0x40 and inst 1000_0010.
- `redirect` and `stall` asserted together: redirect wins; behaviour matches the previous scenario, and the held word is discarded.
- Wrap: RESET_PC=32'hFFFF_FFFC: second fetch has `if_id_pc`=0; `if_id_pc4` of the first instruction is 0.
- Assert `rst` for one cycle mid-stall with `held`=1: the next cycle shows all reset values, then fetch restarts from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage and IF/ID register; clk/rst, stall/redirect(+redirect_pc) control in, imem_addr/imem_rdata to sync imem, if_id_valid/pc/pc4/inst to decode
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [31:0]        if_id_inst
);
  logic [31:0] pc_f;
  logic [31:0] hold_inst;
  logic        held;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      held        <= 1'b0;
      hold_inst   <= 32'h0;
    end else if (redirect) begin
      pc_f        <= {redirect_pc[31:2], 2'b00};
      if_id_valid <= 1'b0;
      held        <= 1'b0;
    end else if (stall) begin
      if (!held) begin
        hold_inst <= imem_rdata;
        held      <= 1'b1;
      end
    end else begin
      if_id_pc    <= pc_f;
      if_id_valid <= 1'b1;
      pc_f        <= pc_f + 32'd4;
      held        <= 1'b0;
    end
  end
  always_comb begin
    imem_addr  = pc_f[IMEM_AW+1:2];
    if_id_pc4  = if_id_pc + 32'd4;
    if_id_inst = !if_id_valid ? NOP_INST : held ? hold_inst : imem_rdata;
  end
endmodule
